// File: rtl/mic_capture_ctrl.sv
// Avalon-MM control/status block for the 4-mic capture DMA.
// Runs the DMA start/FINISHED handshake, ping-pongs between two host buffers,
// tracks host ownership (FULL) of each buffer and raises a level interrupt.
module mic_capture_ctrl #(
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned SAMPLE_BYTES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  AVS_ADDRESS,
  input  logic        AVS_READ,
  input  logic        AVS_WRITE,
  input  logic [31:0] AVS_WRITEDATA,
  output logic [31:0] AVS_READDATA,
  output logic        DMA_START,
  output logic [31:0] DMA_START_ADDR,
  output logic [31:0] DMA_NUM_SAMPLES,
  input  logic        DMA_FINISHED,
  output logic        IRQ
);

  localparam int unsigned GapW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  localparam logic [2:0] AddrCtrl       = 3'd0;
  localparam logic [2:0] AddrStatus     = 3'd1;
  localparam logic [2:0] AddrBuf0       = 3'd2;
  localparam logic [2:0] AddrBuf1       = 3'd3;
  localparam logic [2:0] AddrNumSamples = 3'd4;
  localparam logic [2:0] AddrBlockCount = 3'd5;
  localparam logic [2:0] AddrBufAck     = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRun,
    StRelease,
    StWaitBuf
  } state_e;

  state_e            state_q, state_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              target_q, target_d;
  logic              active_buf_q, active_buf_d;
  logic              ctrl_enable_q, ctrl_enable_d;
  logic              ctrl_cont_q, ctrl_cont_d;
  logic              ctrl_irq_en_q, ctrl_irq_en_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              err_q, err_d;
  logic [1:0]        full_q, full_d;
  logic [31:0]       buf0_addr_q, buf0_addr_d;
  logic [31:0]       buf1_addr_q, buf1_addr_d;
  logic [31:0]       num_samples_q, num_samples_d;
  logic [31:0]       block_count_q, block_count_d;
  logic [31:0]       dma_addr_q, dma_addr_d;
  logic [31:0]       dma_num_q, dma_num_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              irq_q, irq_d;

  logic              busy;
  logic              no_samples;
  logic              next_buf;
  logic [31:0]       rdata;

  assign busy       = (state_q == StArm) || (state_q == StRun) || (state_q == StRelease);
  // A zero-length block would never raise FINISHED, so it is rejected up front.
  assign no_samples = (num_samples_q == 32'd0) || (SAMPLE_BYTES == 0);
  assign next_buf   = ~target_q;

  // CSR read mux, registered below for a fixed one-cycle read latency.
  always_comb begin
    rdata = 32'd0;
    case (AVS_ADDRESS)
      AddrCtrl:       rdata = {29'd0, ctrl_irq_en_q, ctrl_cont_q, ctrl_enable_q};
      AddrStatus:     rdata = {24'd0, full_q, 1'b0, err_q, overrun_q, done_q, active_buf_q, busy};
      AddrBuf0:       rdata = buf0_addr_q;
      AddrBuf1:       rdata = buf1_addr_q;
      AddrNumSamples: rdata = num_samples_q;
      AddrBlockCount: rdata = block_count_q;
      default:        rdata = 32'd0;
    endcase
  end

  // Next state: software CSR writes first, then FSM/hardware updates so hardware sets win.
  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    target_d      = target_q;
    active_buf_d  = active_buf_q;
    ctrl_enable_d = ctrl_enable_q;
    ctrl_cont_d   = ctrl_cont_q;
    ctrl_irq_en_d = ctrl_irq_en_q;
    done_d        = done_q;
    overrun_d     = overrun_q;
    err_d         = err_q;
    full_d        = full_q;
    buf0_addr_d   = buf0_addr_q;
    buf1_addr_d   = buf1_addr_q;
    num_samples_d = num_samples_q;
    block_count_d = block_count_q;
    dma_addr_d    = dma_addr_q;
    dma_num_d     = dma_num_q;
    readdata_d    = AVS_READ ? rdata : 32'd0;
    irq_d         = ctrl_irq_en_q & (done_q | overrun_q | err_q);

    if (AVS_WRITE) begin
      case (AVS_ADDRESS)
        AddrCtrl: begin
          ctrl_enable_d = AVS_WRITEDATA[0];
          ctrl_cont_d   = AVS_WRITEDATA[1];
          ctrl_irq_en_d = AVS_WRITEDATA[2];
        end
        AddrStatus: begin
          done_d    = done_q & ~AVS_WRITEDATA[2];
          overrun_d = overrun_q & ~AVS_WRITEDATA[3];
          err_d     = err_q & ~AVS_WRITEDATA[4];
        end
        AddrBuf0:       buf0_addr_d   = {AVS_WRITEDATA[31:2], 2'b00};
        AddrBuf1:       buf1_addr_d   = {AVS_WRITEDATA[31:2], 2'b00};
        AddrNumSamples: num_samples_d = AVS_WRITEDATA;
        AddrBlockCount: block_count_d = 32'd0;
        AddrBufAck:     full_d        = full_q & ~AVS_WRITEDATA[1:0];
        default:        ;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (ctrl_enable_q) begin
          if (no_samples) begin
            err_d         = 1'b1;
            ctrl_enable_d = 1'b0;
          end else begin
            target_d     = 1'b0;
            active_buf_d = 1'b0;
            dma_addr_d   = buf0_addr_q;
            dma_num_d    = num_samples_q;
            state_d      = full_q[0] ? StWaitBuf : StArm;
          end
        end
      end
      StArm: begin
        // Hold START until the DMA has cleared FINISHED from the previous block.
        if (!DMA_FINISHED) state_d = StRun;
      end
      StRun: begin
        if (DMA_FINISHED) begin
          full_d[target_q] = 1'b1;
          done_d           = 1'b1;
          block_count_d    = block_count_d + 32'd1;
          gap_cnt_d        = '0;
          state_d          = StRelease;
        end
      end
      StRelease: begin
        if (gap_cnt_q == GapLast) begin
          gap_cnt_d = '0;
          if (!ctrl_cont_q) begin
            ctrl_enable_d = 1'b0;
            state_d       = StIdle;
          end else if (ctrl_enable_q) begin
            target_d = next_buf;
            if (full_q[next_buf]) begin
              overrun_d = 1'b1;
              state_d   = StWaitBuf;
            end else begin
              active_buf_d = next_buf;
              dma_addr_d   = next_buf ? buf1_addr_q : buf0_addr_q;
              dma_num_d    = num_samples_q;
              state_d      = StArm;
            end
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      StWaitBuf: begin
        // target_q already names the buffer being waited on.
        if (!ctrl_enable_q) begin
          state_d = StIdle;
        end else if (!full_q[target_q]) begin
          active_buf_d = target_q;
          dma_addr_d   = target_q ? buf1_addr_q : buf0_addr_q;
          dma_num_d    = num_samples_q;
          state_d      = StArm;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and CSR registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= StIdle;
      gap_cnt_q     <= '0;
      target_q      <= 1'b0;
      active_buf_q  <= 1'b0;
      ctrl_enable_q <= 1'b0;
      ctrl_cont_q   <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      err_q         <= 1'b0;
      full_q        <= 2'b00;
      buf0_addr_q   <= 32'd0;
      buf1_addr_q   <= 32'd0;
      num_samples_q <= 32'd0;
      block_count_q <= 32'd0;
      dma_addr_q    <= 32'd0;
      dma_num_q     <= 32'd0;
      readdata_q    <= 32'd0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      target_q      <= target_d;
      active_buf_q  <= active_buf_d;
      ctrl_enable_q <= ctrl_enable_d;
      ctrl_cont_q   <= ctrl_cont_d;
      ctrl_irq_en_q <= ctrl_irq_en_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
      err_q         <= err_d;
      full_q        <= full_d;
      buf0_addr_q   <= buf0_addr_d;
      buf1_addr_q   <= buf1_addr_d;
      num_samples_q <= num_samples_d;
      block_count_q <= block_count_d;
      dma_addr_q    <= dma_addr_d;
      dma_num_q     <= dma_num_d;
      readdata_q    <= readdata_d;
      irq_q         <= irq_d;
    end
  end

  assign AVS_READDATA    = readdata_q;
  assign DMA_START       = (state_q == StArm) || (state_q == StRun);
  assign DMA_START_ADDR  = dma_addr_q;
  assign DMA_NUM_SAMPLES = dma_num_q;
  assign IRQ             = irq_q;

endmodule
